adpll_phase_detector: RTL and testbench
=======================================

# adpll_phase_detector

- Sampled bang-bang phase detector for the ADPLL, directly upstream of the PLL controller.
- Oversamples the reference and DCO-feedback clocks on a fast system clock and decides which rising edge came first.
- Drives the controller's `p_up`/`p_down` decision pair, a generated `phase_clk` strobe and a lead/lag magnitude for debug.

## Interface

Parameters:
- `MAX_WIN`, 31: maximum edge-separation window in `clk` cycles; also the saturation value of `phase_err`.
- `DEADBAND`, 1: lead/lag counts strictly below this produce no correction. Used only when the deadband feature is compiled in.
- `PCLK_HIGH`, 2: number of `clk` cycles `phase_clk` stays high per decision (≥1).

Ports:
- `clk` input 1: oversampling clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `ref_in` input 1: reference clock, asynchronous to `clk`.
- `fb_in` input 1: divided DCO feedback clock, asynchronous to `clk`.
- `p_up` output 1: feedback leads the reference; DCO must slow down.
- `p_down` output 1: feedback lags the reference; DCO must speed up.
- `phase_clk` output 1: decision strobe; the controller samples on its rising edge.
- `phase_err` output ERR_W: magnitude of the last decision. ERR_W = $clog2(MAX_WIN+1).

## Operation

Synchronisation:
- `ref_in` and `fb_in` each pass through a 2-flop synchroniser plus one history flop.
- A rising-edge pulse is produced when sync=1 and hist=0.
- Both paths have identical latency, so that latency cancels in the comparison.

FSM states: IDLE, WAIT_FB, WAIT_REF, DECIDE, STROBE.
- **IDLE**
  - ref pulse only → WAIT_FB with cnt=1.
  - fb pulse only → WAIT_REF with cnt=1.
  - Both in the same cycle → DECIDE with cnt=0 (aligned).
- **WAIT_FB / WAIT_REF**
  - cnt increments each cycle, saturating at MAX_WIN.
  - Awaited edge arrives → DECIDE.
  - cnt reaches MAX_WIN → DECIDE (saturated decision).
  - A second edge of the same input that started the wait → DECIDE immediately, using the current cnt.
- **DECIDE** (one cycle): register the outputs.
  - Direction comes from the start state: WAIT_FB → `p_down`=1, `p_up`=0. WAIT_REF → `p_up`=1, `p_down`=0. Aligned → both 0.
  - `phase_err` ← cnt.
  - Then → STROBE.
- **STROBE**
  - `phase_clk` is high for PCLK_HIGH cycles, then low for at least 1 cycle, then → IDLE.
  - Edges arriving in DECIDE/STROBE are ignored; no queuing.
- `p_up`/`p_down`/`phase_err` change only in DECIDE. They stay stable through the whole strobe and until the next DECIDE.
- `p_up` and `p_down` are never both 1.

## Timing

- Reset values: `p_up`=0, `p_down`=0, `phase_clk`=0, `phase_err`=0, FSM=IDLE, cnt=0, synchroniser/history flops=0.
- Reset asserted mid-operation aborts any wait or strobe. `phase_clk` drops asynchronously.
- Pin-to-edge-pulse latency: 3 `clk` cycles.
- Second-edge pulse to outputs registered: 1 cycle (DECIDE).
- `phase_clk` rises 1 cycle after the outputs change, giving the controller one full `clk` of setup margin.
- Minimum spacing between decisions: PCLK_HIGH+3 cycles.
- cnt arithmetic is unsigned and saturating, never wrapping.

## Configuration

- Macro: `ADPLL_PD_DEADBAND_EN`.
- **Defined:** in DECIDE, if cnt < DEADBAND, force both `p_up` and `p_down` to 0. `phase_err` still records cnt, and `phase_clk` still strobes.
- **Undefined:** any nonzero cnt produces a decision. `DEADBAND` is ignored.

## Structure

- Shared package `adpll_pkg`:
  - FSM state enum.
  - Default parameter constants.
  - ERR_W derivation function.
- One sub-module, `adpll_edge_sync`: 2-flop synchroniser, history flop and rising-edge pulse. Instantiated twice.

## Test plan

- **Fb lags:** ref edge, fb edge 5 cycles later (MAX_WIN=31) → `p_down`=1, `p_up`=0, `phase_err`=5. `phase_clk` high 2 cycles, starting 1 cycle after the outputs change.
- **Fb leads:** fb edge, ref edge 7 cycles later → `p_up`=1, `p_down`=0, `phase_err`=7.
- **Aligned edges:** both edges in the same cycle → `p_up`=`p_down`=0, `phase_err`=0, `phase_clk` still strobes once.
- **Timeout:** ref edge, no fb edge for 40 cycles → saturated decision with `p_down`=1, `phase_err`=31. Fb edges during STROBE produce no second decision.
- **Deadband** (`ADPLL_PD_DEADBAND_EN`, DEADBAND=3):
  - Lag of 2 → both outputs 0, `phase_err`=2.
  - Lag of 3 → `p_down`=1.
- **Reset mid-wait:** assert `reset` in WAIT_FB → all outputs 0 immediately. After release, the next edge pair decides normally.

Source files
------------

// File: rtl/adpll_pkg.sv
// ---------------------------------------------------------------------------
// adpll_pkg
// Shared definitions for the ADPLL phase detector:
//   - pd_state_t : phase-detector FSM state encoding (also exported on the
//                  detector's debug state port)
//   - DEF_*      : default parameter values
//   - err_w()    : width of the lead/lag magnitude for a given window
// ---------------------------------------------------------------------------
package adpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_FB  = 3'd1,
        ST_WAIT_REF = 3'd2,
        ST_DECIDE   = 3'd3,
        ST_STROBE   = 3'd4
    } pd_state_t;

    localparam int DEF_MAX_WIN   = 31;
    localparam int DEF_DEADBAND  = 1;
    localparam int DEF_PCLK_HIGH = 2;

    // Enough bits to hold 0..max_win inclusive.
    function automatic int err_w(input int max_win);
        return $clog2(max_win + 1);
    endfunction

endpackage

// File: rtl/adpll_edge_sync.sv
// ---------------------------------------------------------------------------
// adpll_edge_sync
// Brings an asynchronous clock-like input into the clk domain and produces a
// one-cycle pulse on each rising edge. Two synchroniser flops are followed by
// one history flop; the pulse is sync & ~hist. Both detector inputs use this
// same block, so the synchronisation latency is identical on both paths and
// cancels out of the lead/lag measurement.
//
// Ports:
//   clk      in  oversampling clock
//   reset    in  asynchronous active-high reset (all flops to 0)
//   i_async  in  asynchronous input
//   o_pulse  out one-cycle rising-edge pulse, clk domain
// ---------------------------------------------------------------------------
module adpll_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_hist;

endmodule

// File: rtl/adpll_phase_detector.sv
// ---------------------------------------------------------------------------
// adpll_phase_detector
// Sampled bang-bang phase detector. Oversamples ref_in and fb_in on clk,
// measures which rising edge came first and by how many clk cycles, and
// hands a registered decision to the PLL controller.
//
// Decision contract with the controller: p_up / p_down / phase_err are
// updated only when the FSM leaves DECIDE and then held until the next
// decision. phase_clk rises one clk later, stays high PCLK_HIGH cycles and
// is low for at least one cycle before the next decision can begin, so the
// controller may sample on the rising edge of phase_clk with a full clk of
// setup margin.
//
// Parameters:
//   MAX_WIN    maximum edge separation counted; phase_err saturates here
//   DEADBAND   counts below this give no correction (deadband build only)
//   PCLK_HIGH  phase_clk high time in clk cycles (>= 1)
//
// Ports:
//   clk        in  oversampling clock
//   reset      in  asynchronous active-high reset
//   ref_in     in  reference clock (asynchronous)
//   fb_in      in  divided DCO feedback clock (asynchronous)
//   p_up       out feedback leads reference: slow the DCO
//   p_down     out feedback lags reference: speed the DCO up
//   phase_clk  out decision strobe
//   phase_err  out magnitude of the last decision (ERR_W bits)
//   dbg_state  out current FSM state
//
// Build option: define ADPLL_PD_DEADBAND_EN to suppress p_up/p_down when the
// measured separation is below DEADBAND (phase_err and phase_clk unaffected).
// ---------------------------------------------------------------------------
module adpll_phase_detector
    import adpll_pkg::*;
#(
    parameter  int MAX_WIN   = DEF_MAX_WIN,
    parameter  int DEADBAND  = DEF_DEADBAND,
    parameter  int PCLK_HIGH = DEF_PCLK_HIGH,
    localparam int ERR_W     = err_w(MAX_WIN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic             p_up,
    output logic             p_down,
    output logic             phase_clk,
    output logic [ERR_W-1:0] phase_err,
    output pd_state_t        dbg_state
);

    localparam logic [ERR_W-1:0]  CNT_MAX   = ERR_W'(MAX_WIN);
    localparam logic [ERR_W-1:0]  CNT_ONE   = ERR_W'(1);
    localparam int                SCNT_W    = $clog2(PCLK_HIGH + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(PCLK_HIGH);

    // Effective deadband threshold: zero when the feature is compiled out,
    // so every measured separation produces a decision.
`ifdef ADPLL_PD_DEADBAND_EN
    localparam int DB_EFF = DEADBAND;
`else
    localparam int DB_EFF = 0 * DEADBAND;
`endif

    logic w_ref_pulse;
    logic w_fb_pulse;
    logic w_in_deadband;

    pd_state_t         r_state;
    logic [ERR_W-1:0]  r_cnt;
    logic [SCNT_W-1:0] r_scnt;
    logic              r_want_up;
    logic              r_want_down;
    logic              r_p_up;
    logic              r_p_down;
    logic              r_phase_clk;
    logic [ERR_W-1:0]  r_phase_err;

    adpll_edge_sync u_ref_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (ref_in),
        .o_pulse (w_ref_pulse)
    );

    adpll_edge_sync u_fb_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (fb_in),
        .o_pulse (w_fb_pulse)
    );

    assign w_in_deadband = (int'(r_cnt) < DB_EFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_scnt      <= '0;
            r_want_up   <= 1'b0;
            r_want_down <= 1'b0;
            r_p_up      <= 1'b0;
            r_p_down    <= 1'b0;
            r_phase_clk <= 1'b0;
            r_phase_err <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ref_pulse && w_fb_pulse) begin
                        // Aligned edges: zero error, no correction.
                        r_state     <= ST_DECIDE;
                        r_cnt       <= '0;
                        r_want_up   <= 1'b0;
                        r_want_down <= 1'b0;
                    end else if (w_ref_pulse) begin
                        // Reference first: feedback lags, DCO must speed up.
                        r_state     <= ST_WAIT_FB;
                        r_cnt       <= CNT_ONE;
                        r_want_up   <= 1'b0;
                        r_want_down <= 1'b1;
                    end else if (w_fb_pulse) begin
                        // Feedback first: feedback leads, DCO must slow down.
                        r_state     <= ST_WAIT_REF;
                        r_cnt       <= CNT_ONE;
                        r_want_up   <= 1'b1;
                        r_want_down <= 1'b0;
                    end
                end

                // A repeat edge of the starting input also closes the window:
                // the other input has missed a whole period, decide now.
                // Leaving at CNT_MAX keeps the counter from ever wrapping.
                ST_WAIT_FB: begin
                    if (w_fb_pulse || w_ref_pulse || (r_cnt == CNT_MAX)) begin
                        r_state <= ST_DECIDE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_REF: begin
                    if (w_ref_pulse || w_fb_pulse || (r_cnt == CNT_MAX)) begin
                        r_state <= ST_DECIDE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DECIDE: begin
                    r_p_up      <= r_want_up   && !w_in_deadband;
                    r_p_down    <= r_want_down && !w_in_deadband;
                    r_phase_err <= r_cnt;
                    r_scnt      <= '0;
                    r_state     <= ST_STROBE;
                end

                // phase_clk high for PCLK_HIGH cycles, then one low cycle
                // (the cycle spent back in IDLE) before any new decision.
                ST_STROBE: begin
                    if (r_scnt == SCNT_LAST) begin
                        r_phase_clk <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_phase_clk <= 1'b1;
                        r_scnt      <= r_scnt + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign p_up      = r_p_up;
    assign p_down    = r_p_down;
    assign phase_clk = r_phase_clk;
    assign phase_err = r_phase_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_adpll_phase_detector.sv
// ---------------------------------------------------------------------------
// tb_adpll_phase_detector
// Directed and randomized edge pairs driven on clk negedges, checked against
// a behavioural model of the decision rules (who came first, separation,
// saturation at MAX_WIN, optional deadband).
// ---------------------------------------------------------------------------
module tb_adpll_phase_detector;
    import adpll_pkg::*;

    localparam int MAX_WIN   = 31;
    localparam int DEADBAND  = 3;
    localparam int PCLK_HIGH = 2;
    localparam int ERR_W     = err_w(MAX_WIN);
`ifdef ADPLL_PD_DEADBAND_EN
    localparam int DB_MODEL = DEADBAND;
`else
    localparam int DB_MODEL = 0;
`endif

    // Edge-pattern kinds
    localparam int K_REF_FIRST = 0;
    localparam int K_FB_FIRST  = 1;
    localparam int K_ALIGNED   = 2;
    localparam int K_REF_ONLY  = 3;
    localparam int K_REF_TWICE = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ref_in;
    logic             fb_in;
    logic             p_up;
    logic             p_down;
    logic             phase_clk;
    logic [ERR_W-1:0] phase_err;
    pd_state_t        dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    adpll_phase_detector #(
        .MAX_WIN   (MAX_WIN),
        .DEADBAND  (DEADBAND),
        .PCLK_HIGH (PCLK_HIGH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ref_in    (ref_in),
        .fb_in     (fb_in),
        .p_up      (p_up),
        .p_down    (p_down),
        .phase_clk (phase_clk),
        .phase_err (phase_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    // Reference model: decision from the edge pattern and separation.
    function automatic void model(input int kind, input int gap,
                                  output logic up, output logic down, output int err);
        int sep;
        if (kind == K_ALIGNED)       sep = 0;
        else if (kind == K_REF_ONLY) sep = MAX_WIN;
        else                         sep = (gap > MAX_WIN) ? MAX_WIN : gap;
        err  = sep;
        up   = (kind == K_FB_FIRST);
        down = (kind == K_REF_FIRST) || (kind == K_REF_ONLY) || (kind == K_REF_TWICE);
        if (sep < DB_MODEL) begin
            up   = 1'b0;
            down = 1'b0;
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_edges(input int kind, input int gap);
        @(negedge clk);
        case (kind)
            K_ALIGNED:  begin ref_in = 1'b1; fb_in = 1'b1; end
            K_FB_FIRST: fb_in = 1'b1;
            default:    ref_in = 1'b1;
        endcase
        if (kind != K_ALIGNED && kind != K_REF_ONLY) begin
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                if (kind == K_REF_TWICE && i == 0) ref_in = 1'b0;
            end
            case (kind)
                K_FB_FIRST: ref_in = 1'b1;
                K_REF_TWICE: ref_in = 1'b1;
                default:    fb_in = 1'b1;
            endcase
        end
    endtask

    task automatic release_pins();
        @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Wait for the strobe; check outputs were valid the cycle before it rose,
    // match the model, stay stable and the strobe lasts PCLK_HIGH cycles.
    task automatic await_strobe(input string tag, input logic eu, input logic ed, input int ee);
        int   waited = 0;
        int   hi = 0;
        logic seen = 1'b0;
        logic stable = 1'b1;
        logic prev_up = 1'b0;
        logic prev_down = 1'b0;
        logic [ERR_W-1:0] prev_err = '0;
        while (!seen && waited < 200) begin
            @(negedge clk);
            waited++;
            if (phase_clk) seen = 1'b1;
            else begin
                prev_up   = p_up;
                prev_down = p_down;
                prev_err  = phase_err;
            end
        end
        check(tag, "strobe_seen", 32'(seen), 32'd1);
        if (seen) begin
            check(tag, "setup_p_up",      32'(prev_up),   32'(eu));
            check(tag, "setup_p_down",    32'(prev_down), 32'(ed));
            check(tag, "setup_phase_err", 32'(prev_err),  32'(ee));
            check(tag, "p_up",      32'(p_up),      32'(eu));
            check(tag, "p_down",    32'(p_down),    32'(ed));
            check(tag, "phase_err", 32'(phase_err), 32'(ee));
            hi = 1;
            while (phase_clk && hi < 20) begin
                @(negedge clk);
                if (phase_clk) hi++;
                if (p_up !== eu || p_down !== ed || phase_err !== ERR_W'(ee)) stable = 1'b0;
            end
            check(tag, "strobe_high_cycles", 32'(hi), 32'(PCLK_HIGH));
            check(tag, "outputs_stable", 32'(stable), 32'd1);
        end
    endtask

    task automatic run_trial(input string tag, input int kind, input int gap);
        logic eu, ed;
        int   ee;
        model(kind, gap, eu, ed, ee);
        drive_edges(kind, gap);
        await_strobe(tag, eu, ed, ee);
        release_pins();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic eu, ed;
        int   ee;
        int   extra;
        int   waited;
        logic seen;
        int   kind;
        int   gap;

        reset  = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", "p_up",      32'(p_up),      32'd0);
        check("reset", "p_down",    32'(p_down),    32'd0);
        check("reset", "phase_clk", 32'(phase_clk), 32'd0);
        check("reset", "phase_err", 32'(phase_err), 32'd0);
        check("reset", "state",     32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_trial("fb_lags",   K_REF_FIRST, 5);
        run_trial("fb_leads",  K_FB_FIRST,  7);
        run_trial("aligned",   K_ALIGNED,   0);
        run_trial("ref_twice", K_REF_TWICE, 6);
        run_trial("lag2",      K_REF_FIRST, 2);
        run_trial("lag3",      K_REF_FIRST, 3);
        run_trial("lag1",      K_FB_FIRST,  1);
        run_trial("max_gap",   K_REF_FIRST, MAX_WIN);

        // Timeout: ref only; a fb edge landing during DECIDE/STROBE is ignored.
        model(K_REF_ONLY, 0, eu, ed, ee);
        @(negedge clk);
        ref_in = 1'b1;
        repeat (33) @(negedge clk);
        fb_in = 1'b1;
        await_strobe("timeout", eu, ed, ee);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (phase_clk) extra++;
        end
        check("timeout", "no_second_decision", 32'(extra), 32'd0);
        check("timeout", "state_idle", 32'(dbg_state), 32'(ST_IDLE));
        release_pins();

        // Reset while waiting for fb: outputs clear at once.
        @(negedge clk);
        ref_in = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_wait", "p_up",      32'(p_up),      32'd0);
        check("reset_wait", "p_down",    32'(p_down),    32'd0);
        check("reset_wait", "phase_err", 32'(phase_err), 32'd0);
        check("reset_wait", "phase_clk", 32'(phase_clk), 32'd0);
        check("reset_wait", "state",     32'(dbg_state), 32'(ST_IDLE));
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_trial("after_reset", K_FB_FIRST, 4);

        // Reset during the strobe: phase_clk drops without waiting for clk.
        drive_edges(K_REF_FIRST, 9);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 100) begin
            @(negedge clk);
            waited++;
            if (phase_clk) seen = 1'b1;
        end
        check("reset_strobe", "strobe_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_strobe", "phase_clk", 32'(phase_clk), 32'd0);
        check("reset_strobe", "p_down",    32'(p_down),    32'd0);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized edge pairs within the window.
        for (int t = 0; t < 12; t++) begin
            kind = int'($urandom_range(2, 0));
            gap  = int'($urandom_range(MAX_WIN, 1));
            run_trial("rand", kind, gap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
